// File: rtl/eth_pkg.sv
// Shared types and constants for the MII Ethernet/IPv4/UDP receive path.
// Holds the CRC step that is shared with the transmit side.
package eth_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_MAC_DST,
    S_MAC_SRC,
    S_MAC_TYPE,
    S_IP_HDR,
    S_UDP_HDR,
    S_PAYLOAD,
    S_TAIL,
    S_DROP
  } state_t;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VIHL      = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

  localparam logic [15:0] MAC_DST_LEN  = 16'd6;
  localparam logic [15:0] MAC_SRC_LEN  = 16'd6;
  localparam logic [15:0] MAC_TYPE_LEN = 16'd2;
  localparam logic [15:0] IP_HDR_LEN   = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(
    input logic [47:0] mac,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ip_byte(
    input logic [31:0] ip,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = ip[31:24];
      2'd1:    b = ip[23:16];
      2'd2:    b = ip[15:8];
      default: b = ip[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_crc32_chk.sv
// Byte-wide reflected CRC-32 accumulator; the register is exposed so
// the caller can compare it with the FCS residue.
module eth_crc32_chk
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        d_valid,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc <= '1;
    else if (init)
      crc <= '1;
    else if (d_valid)
      crc <= crc32_byte(crc, d);
  end

endmodule

// File: rtl/eth_udprx.sv
// MII receive: preamble sync, Ethernet/IPv4/UDP header filter,
// payload streaming and FCS verdict per accepted frame.
module eth_udprx
  import eth_pkg::*;
#(
  parameter bit MAC_FILTER = 1'b1
) (
  input  logic        eth_rx_clk,
  input  logic        reset_n,
  input  logic [3:0]  eth_rx_data,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_er,
  input  logic [47:0] usr_ethaddr_i,
  input  logic [31:0] usr_ipaddr_i,
  input  logic [15:0] usr_udpport_i,
  output logic [7:0]  usr_data_o,
  output logic        usr_dvalid_o,
  output logic        usr_sof_o,
  output logic        usr_eof_o,
  output logic [15:0] usr_len_o,
  output logic [31:0] usr_ipsrc_o,
  output logic        usr_good_o,
  output logic        usr_bad_o
);

  state_t      state;
  logic        phase;
  logic [3:0]  lo_nib;
  logic [15:0] cnt;
  logic [7:0]  hi;
  logic [15:0] udp_len;
  logic [31:0] ip_cap;
  logic        uc_ok;
  logic        bc_ok;
  logic        err;

  logic        accepted;
  logic        in_hdr;
  logic        in_frame;
  logic        byte_stb;
  logic        crc_init;
  logic [7:0]  rx_byte;
  logic        uc_nx;
  logic        bc_nx;
  logic        ip_bad;
  logic [15:0] hw;
  logic [31:0] crc;

  assign rx_byte  = {eth_rx_data, lo_nib};
  assign hw       = {hi, rx_byte};
  assign accepted = (state == S_PAYLOAD) || (state == S_TAIL);
  assign in_hdr   = state inside {S_MAC_DST, S_MAC_SRC, S_MAC_TYPE,
                                  S_IP_HDR, S_UDP_HDR};
  assign in_frame = in_hdr || accepted;
  assign byte_stb = in_frame && eth_rx_dv && phase;
  assign crc_init = (state == S_PRE) && eth_rx_dv && !eth_rx_er
                    && (eth_rx_data == 4'hD);

  assign uc_nx = uc_ok && (rx_byte == mac_byte(usr_ethaddr_i, cnt[2:0]));
  assign bc_nx = bc_ok && (rx_byte == 8'hFF);

  assign ip_bad =
    ((cnt == 16'd0) && (rx_byte != IP_VIHL)) ||
    ((cnt == 16'd9) && (rx_byte != IP_PROTO_UDP)) ||
    ((cnt >= 16'd16) &&
     (rx_byte != ip_byte(usr_ipaddr_i, cnt[1:0])));

  eth_crc32_chk u_crc (
    .clk     (eth_rx_clk),
    .rst_n   (reset_n),
    .init    (crc_init),
    .d_valid (byte_stb),
    .d       (rx_byte),
    .crc     (crc)
  );

  always_ff @(posedge eth_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      phase        <= 1'b0;
      lo_nib       <= '0;
      cnt          <= '0;
      hi           <= '0;
      udp_len      <= '0;
      ip_cap       <= '0;
      uc_ok        <= 1'b0;
      bc_ok        <= 1'b0;
      err          <= 1'b0;
      usr_data_o   <= '0;
      usr_dvalid_o <= 1'b0;
      usr_sof_o    <= 1'b0;
      usr_eof_o    <= 1'b0;
      usr_len_o    <= '0;
      usr_ipsrc_o  <= '0;
      usr_good_o   <= 1'b0;
      usr_bad_o    <= 1'b0;
    end else begin
      usr_dvalid_o <= 1'b0;
      usr_sof_o    <= 1'b0;
      usr_eof_o    <= 1'b0;
      usr_good_o   <= 1'b0;
      usr_bad_o    <= 1'b0;
      if (in_frame && eth_rx_dv) begin
        phase <= ~phase;
        if (!phase)
          lo_nib <= eth_rx_data;
      end
      if (byte_stb)
        cnt <= cnt + 16'd1;
      // dv falling: only an accepted frame earns a verdict
      if (in_frame && !eth_rx_dv) begin
        if (accepted) begin
          if (state == S_TAIL && crc == CRC_RESIDUE && !err)
            usr_good_o <= 1'b1;
          else
            usr_bad_o <= 1'b1;
        end
        state <= S_IDLE;
      end else if (in_hdr && eth_rx_er) begin
        state <= S_DROP;
      end else begin
        if (accepted && eth_rx_er)
          err <= 1'b1;
        unique case (state)
          S_IDLE: begin
            err   <= 1'b0;
            phase <= 1'b0;
            if (eth_rx_dv)
              state <= S_PRE;
          end
          S_PRE: begin
            if (!eth_rx_dv)
              state <= S_IDLE;
            else if (eth_rx_er)
              state <= S_DROP;
            else if (eth_rx_data == 4'hD) begin
              state <= S_MAC_DST;
              phase <= 1'b0;
              cnt   <= '0;
              uc_ok <= 1'b1;
              bc_ok <= 1'b1;
            end else if (eth_rx_data != 4'h5)
              state <= S_DROP;
          end
          S_MAC_DST: if (byte_stb) begin
            uc_ok <= uc_nx;
            bc_ok <= bc_nx;
            if (cnt == MAC_DST_LEN - 16'd1) begin
              cnt   <= '0;
              state <= (!MAC_FILTER || uc_nx || bc_nx)
                       ? S_MAC_SRC : S_DROP;
            end
          end
          S_MAC_SRC: if (byte_stb) begin
            if (cnt == MAC_SRC_LEN - 16'd1) begin
              cnt   <= '0;
              state <= S_MAC_TYPE;
            end
          end
          S_MAC_TYPE: if (byte_stb) begin
            hi <= rx_byte;
            if (cnt == MAC_TYPE_LEN - 16'd1) begin
              cnt   <= '0;
              state <= (hw == ETHTYPE_IPV4) ? S_IP_HDR : S_DROP;
            end
          end
          S_IP_HDR: if (byte_stb) begin
            if (cnt >= 16'd12 && cnt <= 16'd15)
              ip_cap <= {ip_cap[23:0], rx_byte};
            if (ip_bad)
              state <= S_DROP;
            else if (cnt == IP_HDR_LEN - 16'd1) begin
              cnt   <= '0;
              state <= S_UDP_HDR;
            end
          end
          S_UDP_HDR: if (byte_stb) begin
            hi <= rx_byte;
            if (cnt == 16'd3 && hw != usr_udpport_i)
              state <= S_DROP;
            if (cnt == 16'd5) begin
              udp_len <= hw;
              if (hw < 16'd9)
                state <= S_DROP;
            end
            if (cnt == UDP_HDR_LEN - 16'd1) begin
              cnt         <= '0;
              usr_len_o   <= udp_len - 16'd8;
              usr_ipsrc_o <= ip_cap;
              state       <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: if (byte_stb) begin
            usr_dvalid_o <= 1'b1;
            usr_data_o   <= rx_byte;
            usr_sof_o    <= (cnt == 16'd0);
            usr_eof_o    <= (cnt == usr_len_o - 16'd1);
            if (cnt == usr_len_o - 16'd1) begin
              cnt   <= '0;
              state <= S_TAIL;
            end
          end
          S_TAIL: begin
          end
          S_DROP: begin
            if (!eth_rx_dv)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
